// File: rtl/sin_sequencer.sv
// Phase-accumulator sample sequencer: folds the phase into [0, pi/2], converts it to an
// IEEE-754 single angle, kicks an external sine unit and captures its result.
module sin_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_tick,
    input  logic [31:0] phase_inc,
    input  logic [3:0]  prec,
    output logic [31:0] sin_theta,
    output logic [3:0]  sin_prec,
    output logic        sin_start,
    input  logic        sin_done,
    input  logic [31:0] sin_result,
    output logic [31:0] sample,
    output logic        sample_valid,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [2:0] {StIdle, StScale, StConv, StStart, StWait} state_e;

    state_e      state;
    logic [31:0] phase;
    logic [30:0] fold_x;
    logic        fold_neg;
    logic [31:0] scaled_t;
    logic        wait_first;

    logic [30:0] x_next;
    logic [63:0] product;
    logic [31:0] t_next;
    logic [4:0]  lead;
    logic [31:0] norm;
    logic [31:0] theta_next;
    logic        unused_bits;

    // Odd quadrants mirror the angle so x always measures distance from the nearer axis.
    assign x_next = phase[30] ? (31'h4000_0000 - {1'b0, phase[29:0]}) : {1'b0, phase[29:0]};

    // 0x6487ED51 is pi/2 in Q1.30 of a quarter turn, so t lands in Q2.30 radians.
    assign product = {33'b0, fold_x} * 64'h6487_ED51;
    assign t_next  = product[61:30];

    always_comb begin
        lead = '0;
        for (int i = 0; i < 32; i++) begin
            if (scaled_t[i]) begin
                lead = 5'(i);
            end
        end
    end

    // Normalise so the leading one sits at bit 31; the 23 bits below it are the mantissa.
    assign norm       = scaled_t << (5'd31 - lead);
    assign theta_next = (scaled_t == 32'd0) ? 32'd0
                                            : {fold_neg, 8'd97 + {3'b0, lead}, norm[30:8]};

    assign unused_bits = ^{product[63:62], product[29:0], norm[31], norm[7:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= StIdle;
            phase        <= '0;
            fold_x       <= '0;
            fold_neg     <= 1'b0;
            scaled_t     <= '0;
            wait_first   <= 1'b0;
            sin_theta    <= '0;
            sin_prec     <= '0;
            sin_start    <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sin_start    <= 1'b0;
            sample_valid <= 1'b0;
            if (sample_tick && state != StIdle) begin
                overrun <= 1'b1;
            end
            case (state)
                StIdle: begin
                    if (sample_tick) begin
                        phase    <= phase + phase_inc;
                        fold_x   <= x_next;
                        fold_neg <= phase[31];
                        sin_prec <= prec;
                        busy     <= 1'b1;
                        state    <= StScale;
                    end
                end
                StScale: begin
                    scaled_t <= t_next;
                    state    <= StConv;
                end
                StConv: begin
                    sin_theta <= theta_next;
                    sin_start <= 1'b1;
                    state     <= StStart;
                end
                StStart: begin
                    wait_first <= 1'b1;
                    state      <= StWait;
                end
                StWait: begin
                    // sin_done may still show the unit's pre-start idle level on the first cycle.
                    wait_first <= 1'b0;
                    if (!wait_first && sin_done) begin
                        sample       <= sin_result;
                        sample_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= StIdle;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sin_sequencer.sv
// Bench for sin_sequencer: stub sine unit echoes theta after a programmable delay; expected
// angles are queued at tick time and scored when the DUT starts the unit and emits a sample.
module tb_sin_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sample_tick = 1'b0;
    logic [31:0] phase_inc = '0;
    logic [3:0]  prec = '0;
    logic [31:0] sin_theta;
    logic [3:0]  sin_prec;
    logic        sin_start;
    logic        sin_done;
    logic [31:0] sin_result;
    logic [31:0] sample;
    logic        sample_valid;
    logic        busy;
    logic        overrun;

    sin_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .phase_inc    (phase_inc),
        .prec         (prec),
        .sin_theta    (sin_theta),
        .sin_prec     (sin_prec),
        .sin_start    (sin_start),
        .sin_done     (sin_done),
        .sin_result   (sin_result),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int valid_cyc = 0;
    int valid_cnt = 0;
    int start_cnt = 0;
    int valid_base = 0;
    int stub_d = 1;
    int stub_cnt = 0;
    logic        stub_done;
    logic [31:0] stub_val;
    logic [31:0] theta_q[$];
    logic [31:0] sample_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Stub sine unit: done stays high through the first WAIT cycle, then low until the delay ends.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            stub_done <= 1'b1;
            stub_cnt  <= 0;
            stub_val  <= '0;
        end else if (sin_start) begin
            stub_cnt <= stub_d + 1;
            stub_val <= sin_theta;
        end else if (stub_cnt > 0) begin
            stub_cnt  <= stub_cnt - 1;
            stub_done <= (stub_cnt <= 2);
        end
    end
    assign sin_done   = stub_done;
    assign sin_result = stub_done ? stub_val : 32'hDEAD_BEEF;

    always @(negedge clk) begin
        if (reset) begin
            if (sin_start) begin
                start_cnt++;
                check("theta_expected", 32'(theta_q.size() != 0), 32'd1);
                if (theta_q.size() != 0) begin
                    logic [31:0] e;
                    e = theta_q.pop_front();
                    check("sin_theta", sin_theta, e);
                    sample_q.push_back(e);
                end
            end
            if (sample_valid) begin
                valid_cnt++;
                valid_cyc = cyc;
                check("sample_expected", 32'(sample_q.size() != 0), 32'd1);
                if (sample_q.size() != 0) begin
                    check("sample", sample, sample_q.pop_front());
                end
            end
        end
    end

    // Called at posedge+1 with the DUT idle.
    task automatic do_tick(input logic [31:0] exp_theta);
        theta_q.push_back(exp_theta);
        valid_base  = valid_cnt;
        sample_tick = 1'b1;
        @(posedge clk);
        #1;
        accept_cyc  = cyc;
        sample_tick = 1'b0;
    endtask

    task automatic wait_valid(input int limit);
        int k = 0;
        while (valid_cnt == valid_base && k < limit) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("valid_count", 32'(valid_cnt - valid_base), 32'd1);
    endtask

    task automatic sample_one(input logic [31:0] exp_theta, input int lat);
        do_tick(exp_theta);
        wait_valid(60);
        check("latency", 32'(valid_cyc - accept_cyc), 32'(lat));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        theta_q.delete();
        sample_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int s0;
        int v0;
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_sample", sample, 32'd0);
        check("rst_theta", sin_theta, 32'd0);
        check("rst_prec", 32'(sin_prec), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_start", 32'(sin_start), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Quarter steps
        phase_inc = 32'h4000_0000;
        prec      = 4'h5;
        stub_d    = 1;
        s0        = start_cnt;
        do_tick(32'h0000_0000);
        check("busy_running", 32'(busy), 32'd1);
        wait_valid(60);
        check("latency", 32'(valid_cyc - accept_cyc), 32'd5);
        check("busy_idle", 32'(busy), 32'd0);
        sample_one(32'h3FC9_0FDA, 5);
        sample_one(32'h0000_0000, 5);
        sample_one(32'hBFC9_0FDA, 5);
        check("q_prec", 32'(sin_prec), 32'h5);
        check("q_starts", 32'(start_cnt - s0), 32'd4);

        // Eighth turn, then long sine delay
        do_reset();
        phase_inc = 32'h2000_0000;
        sample_one(32'h0000_0000, 5);
        sample_one(32'h3F49_0FDA, 5);
        stub_d = 5;
        s0     = start_cnt;
        sample_one(32'h3FC9_0FDA, 9);
        check("d5_starts", 32'(start_cnt - s0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("d5_one_valid", 32'(valid_cnt - valid_base), 32'd1);

        // Overrun: ticks dropped in CONV and WAIT
        do_reset();
        phase_inc = 32'h4000_0000;
        stub_d    = 3;
        do_tick(32'h0000_0000);
        @(posedge clk);
        #1;
        sample_tick = 1'b1;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        check("ovr_set", 32'(overrun), 32'd1);
        @(posedge clk);
        #1;
        sample_tick = 1'b1;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        wait_valid(60);
        check("ovr_latency", 32'(valid_cyc - accept_cyc), 32'd7);
        repeat (4) @(posedge clk);
        #1;
        check("ovr_one_valid", 32'(valid_cnt - valid_base), 32'd1);
        check("ovr_held", 32'(overrun), 32'd1);
        stub_d = 1;
        sample_one(32'h3FC9_0FDA, 5);
        sample_one(32'h0000_0000, 5);
        sample_one(32'hBFC9_0FDA, 5);

        // Wrap: phases 0, FFFFFFFF, FFFFFFFE
        phase_inc = 32'hFFFF_FFFF;
        prec      = 4'h9;
        sample_one(32'h0000_0000, 5);
        sample_one(32'hB080_0000, 5);
        sample_one(32'hB140_0000, 5);
        check("wrap_prec", 32'(sin_prec), 32'h9);
        check("wrap_overrun", 32'(overrun), 32'd1);

        // Reset while in WAIT
        stub_d = 10;
        do_tick(32'hB180_0000);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        theta_q.delete();
        sample_q.delete();
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sample", sample, 32'd0);
        check("abort_theta", sin_theta, 32'd0);
        check("abort_prec", 32'(sin_prec), 32'd0);
        check("abort_overrun", 32'(overrun), 32'd0);
        check("abort_start", 32'(sin_start), 32'd0);
        check("abort_valid", 32'(sample_valid), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        s0 = start_cnt;
        v0 = valid_cnt;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("abort_no_start", 32'(start_cnt - s0), 32'd0);
        stub_d = 1;
        sample_one(32'h0000_0000, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sin_sequencer.md
SIN_SEQUENCER -- requirements
Module: sin_sequencer

Interface
REQ-001 The block SHALL use one clock and asynchronous active-low reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
REQ-004 sample_tick  in  1  request for one new output sample.
REQ-005 phase_inc  in  32  unsigned phase step; 2^32 = one full turn.
REQ-006 prec  in  4  series precision forwarded to the sine unit.
REQ-007 sin_theta  out  32  IEEE-754 single angle in radians, to the sine unit's theta.
REQ-008 sin_prec  out  4  to the sine unit's prec.
REQ-009 sin_start  out  1  one-cycle active-high pulse, to the sine unit's reset.
REQ-010 sin_done  in  1  sine unit done; high while the unit is idle.
REQ-011 sin_result  in  32  sine unit result, IEEE-754 single.
REQ-012 sample  out  32  last captured sine value, IEEE-754 single.
REQ-013 sample_valid  out  1  one-cycle pulse when sample updates.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 overrun  out  1  sticky; set when a tick is dropped.

Function
REQ-016 The phase accumulator SHALL be a 32-bit register; on an accepted tick it SHALL load phase+phase_inc mod 2^32, and the pre-update phase SHALL be the phase of that sample.
REQ-017 A tick SHALL be accepted only in IDLE; prec SHALL be latched onto sin_prec at acceptance.
REQ-018 A tick in any state other than IDLE SHALL be ignored, leave phase unchanged and set overrun.
REQ-019 Folding from p = the sample phase:
- q = p[31:30]
- x = p[29:0] for q=0,2
- x = 2^30 - p[29:0] for q=1,3
- x is 31 bits; neg = q[1].
REQ-020 Scaling SHALL compute t = (x * 0x6487ED51) >> 30, unsigned Q2.30 radians in [0, pi/2].
REQ-021 Conversion of t to float:
- t=0 gives 0x00000000 (never -0).
- Otherwise the exponent SHALL be 127 + (m - 30), where m is the leading-one position.
- The mantissa SHALL be the 23 bits below the leading one, truncated and zero-filled.
- The sign SHALL be neg.
REQ-022 The state machine SHALL have states IDLE, SCALE, CONV, START and WAIT:
- IDLE goes to SCALE on an accepted tick.
- SCALE registers t and goes to CONV.
- CONV registers sin_theta and goes to START.
- START drives sin_start=1 for exactly one cycle and goes to WAIT.
- WAIT SHALL ignore sin_done on its first cycle; afterwards, on sin_done=1 it SHALL load sample<=sin_result, pulse sample_valid and go to IDLE.
REQ-023 Latency from the accepting edge to the sample_valid edge SHALL be 4 + D cycles, where D (≥1) is the number of WAIT cycles after the first until sin_done is seen.
REQ-024 sin_theta and sin_prec SHALL hold stable from CONV exit until the next accepted tick.
REQ-025 A tick arriving in the sample_valid cycle SHALL be accepted, since the state is IDLE.
REQ-026 sin_start SHALL be 0 outside START; the sin_result value SHALL be ignored except on the capture edge.
REQ-027 The block SHALL have no timeout: WAIT SHALL persist until sin_done.

Reset
REQ-028 On reset=0 the block SHALL asynchronously set:
- state=IDLE
- phase=0
- sin_theta=0, sin_prec=0
- sample=0
- sin_start=0, sample_valid=0
- busy=0, overrun=0.
REQ-029 Reset mid-operation SHALL abort the sample, with no sample_valid and no sin_start; the sine unit's own state is don't-care.
REQ-030 overrun SHALL clear only on reset.

Verification
REQ-031 Quarter steps: phase_inc=0x40000000, 4 ticks, stub sine echoing theta with D=1 -> sin_theta 0x00000000, 0x3FC90FDA, 0x00000000, 0xBFC90FDA, and sample equals each in turn.
REQ-032 Eighth turn: phase_inc=0x20000000, 2 ticks -> second sin_theta=0x3F490FDA.
REQ-033 Latency: stub raises sin_done D=5 cycles after the first WAIT cycle -> sample_valid is 9 cycles after the accepting edge, exactly 1 cycle wide, and sin_start is high exactly 1 cycle.
REQ-034 Overrun: tick in CONV and again in WAIT -> both dropped, overrun=1 held, phase advanced once, exactly 1 sample_valid.
REQ-035 Wrap: phase_inc=0xFFFFFFFF, 2 ticks -> sample phases are 0x00000000 and then 0xFFFFFFFF (q3, x=1, neg=1), and the accumulator reads 0xFFFFFFFE.
REQ-036 Reset in WAIT -> outputs at reset values the same cycle, no sample_valid, and the next tick samples phase 0 (theta 0x00000000).
